cpu_trace_buffer: RTL

Parametrised on-chip trace capture unit for the CPU debug probes (PC, STATE, OPCODE, ROM, SP, ADDR and similar 16-bit observation buses). It records a configurable number of probe channels into a circular buffer and stops after a masked value-match trigger plus a programmable post-trigger window. The captured history is then read out in oldest-first order. It sits beside the CPU top level and gives hardware runs the visibility that simulation benches get from waveform dumps.

---
 rtl/cpu_trace_buffer.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
// ----------------
// On-chip trace capture for CPU debug probes. Qualified samples of all probe
// channels are written into a circular buffer until a masked value match (or
// a forced trigger) is seen. Then a programmable number of post-trigger
// samples is written and capture stops. The retained history is read out
// oldest-first, one sample per RD_REQ.
//
// Ports:
//   CLK1_50     system clock, rising edge
//   RST         synchronous active-high reset
//   PROBE       packed probe channels, channel k at [k*CH_WIDTH +: CH_WIDTH]
//   SAMPLE_EN   sample qualifier
//   ARM         pulse: clear buffer, latch trigger settings, start capture
//   FORCE_TRIG  pulse: trigger on the next qualified sample while ARMED
//   TRIG_CH     trigger channel (out-of-range selects channel 0), latched at ARM
//   TRIG_VAL    trigger compare value, latched at ARM
//   TRIG_MASK   trigger compare mask (1 = bit compared), latched at ARM
//   POST_CNT    samples captured after the trigger sample, latched at ARM
//   RD_REQ      read one sample (DONE only)
//   STATE       0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   RD_DATA     read data, holds when RD_VALID is low
//   RD_VALID    one-cycle pulse, one cycle after the accepted RD_REQ
//   FILL        samples held (capture) / samples still unread (DONE)
//   TRIG_POS    readout index of the trigger sample
//   WRAPPED     oldest sample was overwritten at least once since ARM
//
// Read handshake: RD_REQ is accepted on any edge where STATE is DONE, FILL is
// non-zero and ARM is low; the data appears on RD_DATA with RD_VALID high one
// cycle later. There is no back-pressure, so RD_REQ held high streams data.
module cpu_trace_buffer #(
    parameter int CH_WIDTH = 16,
    parameter int CHANNELS = 6,
    parameter int DEPTH    = 256,
    localparam int DW = CHANNELS * CH_WIDTH,
    localparam int AW = $clog2(DEPTH),
    localparam int FW = AW + 1,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic          CLK1_50,
    input  logic          RST,
    input  logic [DW-1:0] PROBE,
    input  logic          SAMPLE_EN,
    input  logic          ARM,
    input  logic          FORCE_TRIG,
    input  logic [CW-1:0] TRIG_CH,
    input  logic [CH_WIDTH-1:0] TRIG_VAL,
    input  logic [CH_WIDTH-1:0] TRIG_MASK,
    input  logic [AW-1:0] POST_CNT,
    input  logic          RD_REQ,
    output logic [1:0]    STATE,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_VALID,
    output logic [FW-1:0] FILL,
    output logic [AW-1:0] TRIG_POS,
    output logic          WRAPPED
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                wrapped_q, wrapped_d;
    logic [AW-1:0]       trig_pos_q, trig_pos_d;
    logic                force_pend_q, force_pend_d;
    logic [AW-1:0]       remain_q, remain_d;
    logic [CW-1:0]       trig_ch_q, trig_ch_d;
    logic [CH_WIDTH-1:0] trig_val_q, trig_val_d;
    logic [CH_WIDTH-1:0] trig_mask_q, trig_mask_d;
    logic [AW-1:0]       post_cnt_q, post_cnt_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DW-1:0]       rd_data_q;

    logic                capture;   // write PROBE at wr_ptr this cycle
    logic                finish;    // this capture is the last one
    logic                rd_en;
    logic [CH_WIDTH-1:0] sel_ch;
    logic                sample_match;
    logic                trig_hit;

    logic [DW-1:0]       mem [DEPTH];

    // Trigger channel mux; unmatched (out-of-range) selects fall back to ch0.
    always_comb begin
        sel_ch = PROBE[CH_WIDTH-1:0];
        for (int k = 1; k < CHANNELS; k++) begin
            if (trig_ch_q == CW'(k)) begin
                sel_ch = PROBE[k*CH_WIDTH +: CH_WIDTH];
            end
        end
    end

    assign sample_match = (((sel_ch ^ trig_val_q) & trig_mask_q) == '0);
    // A force raised in this same cycle counts as pending for this sample.
    assign trig_hit     = sample_match | force_pend_q | FORCE_TRIG;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_d       = fill_q;
        wrapped_d    = wrapped_q;
        trig_pos_d   = trig_pos_q;
        force_pend_d = force_pend_q;
        remain_d     = remain_q;
        trig_ch_d    = trig_ch_q;
        trig_val_d   = trig_val_q;
        trig_mask_d  = trig_mask_q;
        post_cnt_d   = post_cnt_q;
        rd_valid_d   = 1'b0;
        capture      = 1'b0;
        finish       = 1'b0;
        rd_en        = 1'b0;

        if (ARM) begin
            // ARM beats everything: any sample or read this cycle is dropped.
            state_d      = S_ARMED;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            fill_d       = '0;
            wrapped_d    = 1'b0;
            trig_pos_d   = '0;
            force_pend_d = 1'b0;
            remain_d     = '0;
            trig_ch_d    = TRIG_CH;
            trig_val_d   = TRIG_VAL;
            trig_mask_d  = TRIG_MASK;
            post_cnt_d   = POST_CNT;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (FORCE_TRIG) begin
                        force_pend_d = 1'b1;
                    end
                    if (SAMPLE_EN) begin
                        capture = 1'b1;
                        if (trig_hit) begin
                            force_pend_d = 1'b0;
                            if (post_cnt_q == '0) begin
                                state_d = S_DONE;
                                finish  = 1'b1;
                            end else begin
                                state_d  = S_POST;
                                remain_d = post_cnt_q;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (SAMPLE_EN) begin
                        capture  = 1'b1;
                        remain_d = remain_q - AW'(1);
                        if (remain_q == AW'(1)) begin
                            state_d = S_DONE;
                            finish  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (RD_REQ && (fill_q != '0)) begin
                        rd_en      = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        fill_d     = fill_q - FW'(1);
                    end
                end
                default: ;
            endcase
        end

        if (capture) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (fill_q == FW'(DEPTH)) begin
                wrapped_d = 1'b1;
            end else begin
                fill_d = fill_q + FW'(1);
            end
        end

        // Oldest retained sample sits FILL entries behind the write pointer;
        // with FILL==DEPTH the low bits are zero and that is wr_ptr itself.
        if (finish) begin
            rd_ptr_d   = wr_ptr_d - fill_d[AW-1:0];
            trig_pos_d = AW'(fill_d - FW'(1) - FW'(post_cnt_q));
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            wrapped_q    <= 1'b0;
            trig_pos_q   <= '0;
            force_pend_q <= 1'b0;
            remain_q     <= '0;
            trig_ch_q    <= '0;
            trig_val_q   <= '0;
            trig_mask_q  <= '0;
            post_cnt_q   <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
            wrapped_q    <= wrapped_d;
            trig_pos_q   <= trig_pos_d;
            force_pend_q <= force_pend_d;
            remain_q     <= remain_d;
            trig_ch_q    <= trig_ch_d;
            trig_val_q   <= trig_val_d;
            trig_mask_q  <= trig_mask_d;
            post_cnt_q   <= post_cnt_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // Storage: one write port, one registered read port.
    always_ff @(posedge CLK1_50) begin
        if (capture) begin
            mem[wr_ptr_q] <= PROBE;
        end
    end

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign STATE    = state_q;
    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign FILL     = fill_q;
    assign TRIG_POS = trig_pos_q;
    assign WRAPPED  = wrapped_q;

endmodule
